// File: rtl/fwd_pkg.sv
// Shared encodings and helpers for the EX bypass / ID hazard logic.
package fwd_pkg;

  typedef enum logic [1:0] {
    CLS_ALU  = 2'd0,
    CLS_LOAD = 2'd1,
    CLS_MUL  = 2'd2,
    CLS_RSVD = 2'd3
  } cls_e;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction

endpackage

// File: rtl/fwd_mux.sv
// Single-operand priority bypass mux: youngest matching stage wins, r0 never forwards.
// Purely combinational, no flow control.
module fwd_mux
  import fwd_pkg::*;
#(
  parameter int DATA_W  = 32,
  parameter int REG_AW  = 5,
  parameter int NUM_STG = 2
) (
  input  logic [REG_AW-1:0]         src_addr,
  input  logic [DATA_W-1:0]         reg_data,
  input  logic [NUM_STG*REG_AW-1:0] stg_rd,
  input  logic [NUM_STG-1:0]        stg_we,
  input  logic [NUM_STG*DATA_W-1:0] stg_data,
  output logic [DATA_W-1:0]         opnd,
  output logic                      hit
);

  always_comb begin
    opnd = reg_data;
    hit  = 1'b0;
    // Walk oldest to youngest so the youngest match is the last to overwrite.
    for (int s = NUM_STG - 1; s >= 0; s--) begin
      if (stg_we[s] && (src_addr != '0) && (stg_rd[s*REG_AW +: REG_AW] == src_addr)) begin
        opnd = stg_data[s*DATA_W +: DATA_W];
        hit  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/fwd_hazard_unit.sv
// N-operand EX bypass plus per-register readiness scoreboard driving the ID stall.
// Stall and operands are combinational; scoreboard updates one cycle after issue, frozen by hold.
module fwd_hazard_unit
  import fwd_pkg::*;
#(
  parameter int DATA_W  = 32,
  parameter int REG_AW  = 5,
  parameter int NUM_SRC = 2,
  parameter int NUM_STG = 2,
  parameter int LD_LAT  = 2,
  parameter int MUL_LAT = 4
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      hold,
  input  logic                      sb_clear,
  input  logic [NUM_SRC*REG_AW-1:0] id_src_addr,
  input  logic [NUM_SRC-1:0]        id_src_used,
  input  logic [REG_AW-1:0]         id_dst_addr,
  input  logic                      id_dst_we,
  input  logic [1:0]                id_class,
  input  logic                      issue_valid,
  output logic                      stall,
  input  logic [NUM_SRC*REG_AW-1:0] ex_src_addr,
  input  logic [NUM_SRC*DATA_W-1:0] ex_reg_data,
  input  logic [NUM_STG*REG_AW-1:0] stg_rd,
  input  logic [NUM_STG-1:0]        stg_we,
  input  logic [NUM_STG*DATA_W-1:0] stg_data,
  output logic [NUM_SRC*DATA_W-1:0] ex_opnd,
  output logic [NUM_SRC-1:0]        ex_fwd_hit,
  output logic [31:0]               stall_cycles
);

  localparam int CNT_W = clog2(MUL_LAT + 1);
  localparam int NREG  = 1 << REG_AW;

  logic [CNT_W-1:0]  cnt [NREG];
  logic [CNT_W-1:0]  new_lat_m1;
  logic [REG_AW-1:0] src_a;
  logic              raw_hz;
  logic              waw_hz;
  logic              issue_wr;

  always_comb begin
    case (id_class)
      CLS_LOAD: new_lat_m1 = CNT_W'(LD_LAT - 1);
      CLS_MUL:  new_lat_m1 = CNT_W'(MUL_LAT - 1);
      default:  new_lat_m1 = '0;
    endcase
  end

  always_comb begin
    raw_hz = 1'b0;
    src_a  = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      src_a = id_src_addr[i*REG_AW +: REG_AW];
      if (id_src_used[i] && (src_a != '0) && (cnt[src_a] != '0))
        raw_hz = 1'b1;
    end
  end

  // A newer write must not land before an older, slower one to the same register.
  assign waw_hz   = id_dst_we && (id_dst_addr != '0) && (cnt[id_dst_addr] > new_lat_m1);
  assign stall    = raw_hz | waw_hz;
  assign issue_wr = issue_valid && !stall && !hold && id_dst_we && (id_dst_addr != '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int r = 0; r < NREG; r++) cnt[r] <= '0;
    end else if (sb_clear) begin
      for (int r = 0; r < NREG; r++) cnt[r] <= '0;
    end else if (!hold) begin
      for (int r = 1; r < NREG; r++) begin
        if (issue_wr && (id_dst_addr == REG_AW'(r)))
          cnt[r] <= new_lat_m1;
        else if (cnt[r] != '0)
          cnt[r] <= cnt[r] - 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      stall_cycles <= '0;
    else if (stall && !hold && (stall_cycles != 32'hFFFF_FFFF))
      stall_cycles <= stall_cycles + 32'd1;
  end

  for (genvar g = 0; g < NUM_SRC; g++) begin : g_mux
    fwd_mux #(
      .DATA_W  (DATA_W),
      .REG_AW  (REG_AW),
      .NUM_STG (NUM_STG)
    ) u_mux (
      .src_addr (ex_src_addr[g*REG_AW +: REG_AW]),
      .reg_data (ex_reg_data[g*DATA_W +: DATA_W]),
      .stg_rd   (stg_rd),
      .stg_we   (stg_we),
      .stg_data (stg_data),
      .opnd     (ex_opnd[g*DATA_W +: DATA_W]),
      .hit      (ex_fwd_hit[g])
    );
  end

endmodule

// File: tb/tb_fwd_hazard_unit.sv
// Directed bench for fwd_hazard_unit with hand-computed expectations.
module tb_fwd_hazard_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        hold;
  logic        sb_clear;
  logic [9:0]  id_src_addr;
  logic [1:0]  id_src_used;
  logic [4:0]  id_dst_addr;
  logic        id_dst_we;
  logic [1:0]  id_class;
  logic        issue_valid;
  logic        stall;
  logic [9:0]  ex_src_addr;
  logic [63:0] ex_reg_data;
  logic [9:0]  stg_rd;
  logic [1:0]  stg_we;
  logic [63:0] stg_data;
  logic [63:0] ex_opnd;
  logic [1:0]  ex_fwd_hit;
  logic [31:0] stall_cycles;

  int n_chk  = 0;
  int n_fail = 0;
  int n_stall;

  always #5 clk = ~clk;

  fwd_hazard_unit dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .hold         (hold),
    .sb_clear     (sb_clear),
    .id_src_addr  (id_src_addr),
    .id_src_used  (id_src_used),
    .id_dst_addr  (id_dst_addr),
    .id_dst_we    (id_dst_we),
    .id_class     (id_class),
    .issue_valid  (issue_valid),
    .stall        (stall),
    .ex_src_addr  (ex_src_addr),
    .ex_reg_data  (ex_reg_data),
    .stg_rd       (stg_rd),
    .stg_we       (stg_we),
    .stg_data     (stg_data),
    .ex_opnd      (ex_opnd),
    .ex_fwd_hit   (ex_fwd_hit),
    .stall_cycles (stall_cycles)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic idle();
    issue_valid = 1'b0;
    id_src_used = 2'b00;
    id_src_addr = '0;
    id_dst_we   = 1'b0;
    id_dst_addr = '0;
    id_class    = 2'd0;
    hold        = 1'b0;
    sb_clear    = 1'b0;
  endtask

  // Issue one producer with no sources, then return to idle.
  task automatic issue_prod(input logic [4:0] dst, input logic [1:0] cls);
    idle();
    id_dst_we   = 1'b1;
    id_dst_addr = dst;
    id_class    = cls;
    issue_valid = 1'b1;
    tick();
    idle();
  endtask

  // Present a pure consumer of register r on source 0.
  task automatic reader(input logic [4:0] r);
    idle();
    id_src_addr[4:0] = r;
    id_src_used      = 2'b01;
    issue_valid      = 1'b1;
    #1;
  endtask

  // Count consecutive stalled cycles with the current ID inputs; hold on given loop indices.
  task automatic count_stall(input int hold_a, input int hold_b, output int n);
    n = 0;
    for (int i = 0; i < 12; i++) begin
      hold = (i == hold_a) || (i == hold_b);
      #1;
      if (!stall) begin
        hold = 1'b0;
        break;
      end
      n++;
      tick();
    end
    hold = 1'b0;
  endtask

  initial begin
    idle();
    ex_src_addr = '0;
    ex_reg_data = '0;
    stg_rd      = '0;
    stg_we      = '0;
    stg_data    = '0;
    rst_n       = 1'b0;
    #12;
    chk("rst_stall", {31'd0, stall}, 32'd0);
    chk("rst_cycles", stall_cycles, 32'd0);
    rst_n = 1'b1;
    tick();

    // ALU producer is forwardable immediately.
    issue_prod(5'd3, 2'd0);
    reader(5'd3);
    chk("alu_no_stall", {31'd0, stall}, 32'd0);
    ex_src_addr = {5'd6, 5'd3};
    ex_reg_data = {32'h0000_0606, 32'h0000_0303};
    stg_rd      = {5'd0, 5'd3};
    stg_we      = 2'b01;
    stg_data    = {32'h0, 32'hAAAA_0001};
    #1;
    chk("alu_fwd_opnd", ex_opnd[31:0], 32'hAAAA_0001);
    chk("alu_fwd_hit", {30'd0, ex_fwd_hit}, 32'd1);
    chk("nomatch_opnd", ex_opnd[63:32], 32'h0000_0606);
    tick();

    // LOAD then dependent: one bubble.
    issue_prod(5'd5, 2'd1);
    reader(5'd5);
    chk("ld_stall", {31'd0, stall}, 32'd1);
    tick();
    #1;
    chk("ld_release", {31'd0, stall}, 32'd0);
    chk("ld_cycles", stall_cycles, 32'd1);
    tick();

    // MUL then dependent with a two-cycle freeze in the middle.
    issue_prod(5'd7, 2'd2);
    reader(5'd7);
    count_stall(1, 2, n_stall);
    chk("mul_hold_stall_len", n_stall, 32'd5);
    chk("mul_cycles", stall_cycles, 32'd4);
    tick();

    // WAW: ALU write behind MUL to same register waits until cnt reaches 0.
    issue_prod(5'd9, 2'd2);
    id_dst_we = 1'b1; id_dst_addr = 5'd9; id_class = 2'd0; issue_valid = 1'b1;
    count_stall(-1, -1, n_stall);
    chk("waw_alu_len", n_stall, 32'd3);
    tick();
    idle();
    // WAW: LOAD behind MUL only needs the MUL counter to fall to 1.
    issue_prod(5'd9, 2'd2);
    id_dst_we = 1'b1; id_dst_addr = 5'd9; id_class = 2'd1; issue_valid = 1'b1;
    count_stall(-1, -1, n_stall);
    chk("waw_ld_len", n_stall, 32'd2);
    tick();
    reader(5'd9);
    chk("waw_ld_overrides", {31'd0, stall}, 32'd1);
    tick();
    #1;
    chk("waw_ld_done", {31'd0, stall}, 32'd0);
    chk("total_cycles", stall_cycles, 32'd10);
    idle();

    // Forwarding priority and r0.
    ex_src_addr = {5'd0, 5'd4};
    ex_reg_data = {32'h0000_DEAD, 32'h0000_0444};
    stg_rd      = {5'd4, 5'd4};
    stg_we      = 2'b11;
    stg_data    = {32'h22, 32'h11};
    #1;
    chk("prio_young", ex_opnd[31:0], 32'h11);
    chk("prio_hit", {30'd0, ex_fwd_hit}, 32'd1);
    stg_we = 2'b10;
    #1;
    chk("prio_old", ex_opnd[31:0], 32'h22);
    stg_rd = {5'd4, 5'd0};
    stg_we = 2'b01;
    #1;
    chk("r0_opnd", ex_opnd[63:32], 32'h0000_DEAD);
    chk("r0_hit", {30'd0, ex_fwd_hit}, 32'd0);
    stg_we = 2'b00;
    #1;
    chk("none_opnd", ex_opnd[31:0], 32'h0444);

    // Issue under hold is dropped; reserved class behaves as ALU.
    idle();
    hold = 1'b1; id_dst_we = 1'b1; id_dst_addr = 5'd10; id_class = 2'd2; issue_valid = 1'b1;
    tick();
    reader(5'd10);
    chk("hold_blocks_issue", {31'd0, stall}, 32'd0);
    issue_prod(5'd11, 2'd3);
    reader(5'd11);
    chk("rsvd_as_alu", {31'd0, stall}, 32'd0);

    // Async reset during a pending MUL.
    issue_prod(5'd7, 2'd2);
    tick();
    reader(5'd7);
    chk("pre_rst_stall", {31'd0, stall}, 32'd1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_stall", {31'd0, stall}, 32'd0);
    chk("mid_rst_cycles", stall_cycles, 32'd0);
    #2;
    rst_n = 1'b1;
    tick();
    chk("post_rst_stall", {31'd0, stall}, 32'd0);

    // Exception flush.
    issue_prod(5'd8, 2'd2);
    reader(5'd8);
    chk("pre_clr_stall", {31'd0, stall}, 32'd1);
    sb_clear = 1'b1;
    tick();
    sb_clear = 1'b0;
    #1;
    chk("post_clr_stall", {31'd0, stall}, 32'd0);

    $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
    $finish;
  end

endmodule
